// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared word width, NOP encoding and reset PC for the pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t NOP_INSTR        = 32'h0000_0000;
    localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        PC_SEL_SEQ      = 2'd0,
        PC_SEL_HOLD     = 2'd1,
        PC_SEL_REDIRECT = 2'd2
    } pc_sel_e;

    function automatic logic is_word_aligned(input word_t addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register with hold and flush controls.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
    import mips_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  hold,
    input  logic  flush,
    input  word_t d_instr,
    input  word_t d_pc_plus4,
    output word_t q_instr,
    output word_t q_pc_plus4,
    output logic  q_valid
);

    word_t r_instr;
    word_t r_pc_plus4;
    logic  r_valid;

    // Flush outranks hold so a redirect during a stall still squashes the slot.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_instr    <= NOP_INSTR;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else if (!hold) begin
            r_instr    <= d_instr;
            r_pc_plus4 <= d_pc_plus4;
            r_valid    <= 1'b1;
        end
    end

    assign q_instr    = r_instr;
    assign q_pc_plus4 = r_pc_plus4;
    assign q_valid    = r_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : PC register, next-PC selection and IF/ID register instance.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] machinecode,
    output logic [31:0] pc_plus4,
    output logic        if_valid,
    output logic        misalign
);

    // Low bits are forced clear so the PC stays word aligned whatever is passed.
    localparam word_t c_RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    word_t   r_pc;
    logic    r_misalign;
    word_t   w_pc_plus4;
    word_t   w_next_pc;
    logic    w_redirect_ok;
    logic    w_redirect_bad;
    pc_sel_e w_pc_sel;

    assign w_pc_plus4     = r_pc + 32'd4;
    assign w_redirect_ok  = redirect && is_word_aligned(redirect_pc);
    assign w_redirect_bad = redirect && !is_word_aligned(redirect_pc);

    always_comb begin
        w_pc_sel = PC_SEL_SEQ;
        if (w_redirect_ok) begin
            w_pc_sel = PC_SEL_REDIRECT;
        end else if (stall || w_redirect_bad) begin
            w_pc_sel = PC_SEL_HOLD;
        end
    end

    always_comb begin
        w_next_pc = w_pc_plus4;
        case (w_pc_sel)
            PC_SEL_REDIRECT: w_next_pc = redirect_pc;
            PC_SEL_HOLD:     w_next_pc = r_pc;
            default:         w_next_pc = w_pc_plus4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= c_RESET_PC_ALIGNED;
            r_misalign <= 1'b0;
        end else begin
            r_pc       <= w_next_pc;
            r_misalign <= w_redirect_bad;
        end
    end

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .hold       (stall && !redirect),
        .flush      (redirect),
        .d_instr    (imem_rdata),
        .d_pc_plus4 (w_pc_plus4),
        .q_instr    (machinecode),
        .q_pc_plus4 (pc_plus4),
        .q_valid    (if_valid)
    );

    assign imem_addr = r_pc;
    assign misalign  = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Randomised and directed checks of fetch_stage against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    logic [31:0] addr [2];
    logic [31:0] rdata [2];
    logic [31:0] mc [2];
    logic [31:0] pp4 [2];
    logic        vld [2];
    logic        mis [2];

    // Model state per instance: index 0 has RESET_PC=0, index 1 has FFFF_FFF8.
    logic [31:0] m_rpc [2];
    logic [31:0] m_pc [2];
    logic [31:0] m_mc [2];
    logic [31:0] m_pp4 [2];
    logic        m_vld [2];
    logic        m_mis [2];

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h2000_0000 + (a >> 2);
    endfunction

    assign rdata[0] = mem_word(addr[0]);
    assign rdata[1] = mem_word(addr[1]);

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut0 (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr(addr[0]), .imem_rdata(rdata[0]),
        .machinecode(mc[0]), .pc_plus4(pp4[0]), .if_valid(vld[0]), .misalign(mis[0])
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr(addr[1]), .imem_rdata(rdata[1]),
        .machinecode(mc[1]), .pc_plus4(pp4[1]), .if_valid(vld[1]), .misalign(mis[1])
    );

    initial begin
        m_rpc[0] = 32'h0000_0000;
        m_rpc[1] = 32'hFFFF_FFF8;
    end

    // Reference behaviour: what each edge must do, stated per input case.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_pc[i] = m_rpc[i]; m_mc[i] = 0; m_pp4[i] = 0; m_vld[i] = 0; m_mis[i] = 0;
            end else if (redirect) begin
                if (redirect_pc % 4 == 0) m_pc[i] = redirect_pc;
                m_mis[i] = (redirect_pc % 4 != 0);
                m_mc[i] = 0; m_pp4[i] = 0; m_vld[i] = 0;
            end else if (stall) begin
                m_mis[i] = 0;
            end else begin
                m_mc[i]  = mem_word(m_pc[i]);
                m_pp4[i] = m_pc[i] + 4;
                m_vld[i] = 1;
                m_pc[i]  = m_pc[i] + 4;
                m_mis[i] = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("imem_addr[%0d]", i), addr[i], m_pc[i]);
                chk($sformatf("machinecode[%0d]", i), mc[i], m_mc[i]);
                chk($sformatf("pc_plus4[%0d]", i), pp4[i], m_pp4[i]);
                chk($sformatf("if_valid[%0d]", i), {31'b0, vld[i]}, {31'b0, m_vld[i]});
                chk($sformatf("misalign[%0d]", i), {31'b0, mis[i]}, {31'b0, m_mis[i]});
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        // Reset and release
        step(); check_en = 1'b1; step();
        chk("rst_addr0", addr[0], 32'h0);
        chk("rst_mc0", mc[0], 32'h0);
        chk("rst_vld0", {31'b0, vld[0]}, 32'h0);
        chk("rst_addr1", addr[1], 32'hFFFF_FFF8);
        rst = 1'b0;
        step();
        chk("first_mc0", mc[0], 32'h2000_0000);
        chk("first_pp40", pp4[0], 32'h4);
        chk("first_vld0", {31'b0, vld[0]}, 32'h1);
        chk("addr0_4", addr[0], 32'h4);
        chk("wrap_addr1_a", addr[1], 32'hFFFF_FFFC);
        chk("wrap_mc1_a", mc[1], 32'h5FFF_FFFE);
        step();
        chk("wrap_addr1_b", addr[1], 32'h0000_0000);
        chk("wrap_mc1_b", mc[1], 32'h5FFF_FFFF);
        chk("wrap_pp41_b", pp4[1], 32'h0000_0000);
        // Stall three cycles at PC=8
        chk("addr0_8", addr[0], 32'h8);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_addr", addr[0], 32'h8);
            chk("stall_mc", mc[0], 32'h2000_0001);
        end
        stall = 1'b0;
        step();
        chk("resume_mc", mc[0], 32'h2000_0002);
        chk("resume_pp4", pp4[0], 32'hC);
        // Redirect beats stall
        redirect = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
        step();
        chk("redir_addr", addr[0], 32'h40);
        chk("redir_mc", mc[0], 32'h0);
        chk("redir_vld", {31'b0, vld[0]}, 32'h0);
        redirect = 1'b0; stall = 1'b0;
        step();
        chk("redir_word", mc[0], 32'h2000_0010);
        chk("redir_vld2", {31'b0, vld[0]}, 32'h1);
        // Misaligned target
        redirect = 1'b1; redirect_pc = 32'h42;
        step();
        chk("mis_flag", {31'b0, mis[0]}, 32'h1);
        chk("mis_addr", addr[0], 32'h44);
        chk("mis_vld", {31'b0, vld[0]}, 32'h0);
        redirect = 1'b0;
        step();
        chk("mis_clear", {31'b0, mis[0]}, 32'h0);
        chk("mis_next", mc[0], 32'h2000_0011);
        // Reset while stall and redirect are pending
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h80; rst = 1'b1;
        step();
        chk("rst2_addr", addr[0], 32'h0);
        chk("rst2_vld", {31'b0, vld[0]}, 32'h0);
        stall = 1'b0; redirect = 1'b0; rst = 1'b0;
        step();
        chk("rst2_first", mc[0], 32'h2000_0000);
        // Random phase
        for (int k = 0; k < 600; k++) begin
            rst      = ($urandom_range(0, 49) == 0);
            stall    = ($urandom_range(0, 3) == 0);
            redirect = ($urandom_range(0, 5) == 0);
            redirect_pc = ($urandom_range(0, 1023) << 2) |
                          (($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
            step();
        end
        rst = 1'b0; stall = 1'b0; redirect = 1'b0;
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
